// File: rtl/div_16_23_pkg.sv
// Shared constants and FSM state type for the divide-by-23 / reconstruct-by-23 blocks.
package div_16_23_pkg;

  localparam int unsigned DIV_CONST = 23;
  localparam int unsigned XW_DEF    = 16;
  localparam int unsigned QW_DEF    = 12;
  localparam int unsigned RW_DEF    = 5;
  localparam int unsigned ACC_W     = 17;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned LAST_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : div_16_23_pkg

// File: rtl/recon_16_23_check.sv
// Flags a remainder outside 0..22 (latched at accept) or a final sum above the XW-bit range.
module recon_16_23_check
  import div_16_23_pkg::*;
#(
  parameter int unsigned XW = XW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [RW-1:0]    r_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic             err_c_o
);

  localparam int unsigned X_MAX = (32'd1 << XW) - 32'd1;

  logic range_q;
  logic range_d;

  always_comb begin
    range_d = range_q;
    if (load_i) begin
      range_d = (32'(r_i) >= DIV_CONST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q <= 1'b0;
    end else begin
      range_q <= range_d;
    end
  end

  assign err_c_o = range_q | (32'(acc_i) > X_MAX);

endmodule : recon_16_23_check

// File: rtl/recon_16_23.sv
// Rebuilds X = Q*23 + R with a five-step shift-add FSM (IDLE -> CALC -> DONE).
// Define RECON_16_23_CHECK_EN to drive ERR_out from range/overflow detection; otherwise ERR_out is 0.
module recon_16_23
  import div_16_23_pkg::*;
#(
  parameter int unsigned XW = XW_DEF,
  parameter int unsigned QW = QW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [QW:1] IN_Q,
  input  logic [RW:1] IN_R,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [XW:1] X_out,
  output logic        ERR_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] K_BITS = 8'(DIV_CONST);

  state_e            state_q, state_d;
  logic [QW-1:0]     q_q, q_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;
  logic [ACC_W-1:0]  acc_step_c;
  logic              err_c;

`ifdef RECON_16_23_CHECK_EN
  logic accept_c;
  assign accept_c = (state_q == IDLE) && in_valid && rdy_q;

  recon_16_23_check #(
    .XW (XW),
    .RW (RW)
  ) u_check (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept_c),
    .r_i     (IN_R),
    .acc_i   (acc_step_c),
    .err_c_o (err_c)
  );
`else
  assign err_c = 1'b0;
`endif

  // Partial product for the current step: Q<<i only where bit i of the constant is set.
  assign acc_step_c = acc_q + (K_BITS[cnt_q] ? (ACC_W'(q_q) << cnt_q) : '0);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    err_d   = err_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          q_d     = IN_Q;
          acc_d   = ACC_W'(IN_R);
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_STEP)) begin
          x_d     = acc_step_c[XW-1:0];
          err_d   = err_c;
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      x_q   <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      q_q   <= q_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      x_q   <= x_d;
      err_q <= err_d;
      vld_q <= vld_d;
      rdy_q <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign X_out     = x_q;
  assign ERR_out   = err_q;
  assign out_valid = vld_q;

endmodule : recon_16_23

// File: tb/tb_recon_16_23.sv
// Directed bench for recon_16_23: latency, overflow/range flags, back-pressure, async reset, round trip.
module tb_recon_16_23;

`ifdef RECON_16_23_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [11:0] in_q;
  logic [4:0]  in_r;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_out;
  logic        err_out;
  logic        out_valid;
  logic        out_ready;

  int n_cmp;
  int n_err;

  recon_16_23 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IN_Q      (in_q),
    .IN_R      (in_r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X_out     (x_out),
    .ERR_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready held high; checks exact 5-edge latency and release.
  task automatic run(input string tag, input int q, input int r, input int ex, input bit ee);
    chk($sformatf("%s.rdy_idle", tag), 32'(in_ready), 32'd1);
    in_q      = 12'(q);
    in_r      = 5'(r);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk($sformatf("%s.rdy_busy", tag), 32'(in_ready), 32'd0);
    for (int k = 1; k < 5; k++) begin
      step();
      chk($sformatf("%s.early_vld%0d", tag, k), 32'(out_valid), 32'd0);
    end
    step();
    chk($sformatf("%s.vld", tag), 32'(out_valid), 32'd1);
    chk($sformatf("%s.x", tag), 32'(x_out), 32'(ex));
    chk($sformatf("%s.err", tag), 32'(err_out), 32'(ee));
    step();
    chk($sformatf("%s.vld_drop", tag), 32'(out_valid), 32'd0);
    chk($sformatf("%s.rdy_back", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_q      = '0;
    in_r      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    #12;
    chk("reset.vld", 32'(out_valid), 32'd0);
    chk("reset.x", 32'(x_out), 32'd0);
    chk("reset.err", 32'(err_out), 32'd0);
    chk("reset.rdy", 32'(in_ready), 32'd1);
    #5;
    rst_n = 1'b1;
    step();

    // in_valid low in IDLE must not start anything
    step();
    step();
    chk("idle.vld", 32'(out_valid), 32'd0);
    chk("idle.rdy", 32'(in_ready), 32'd1);

    run("zero", 0, 0, 0, 1'b0);
    run("max_ok", 2849, 8, 65535, 1'b0);
    run("ovf", 2849, 9, 0, CHK);
    run("range", 10, 23, 253, CHK);
    run("all_ones", 4095, 31, 28680, CHK);
    run("r22", 1, 22, 45, 1'b0);

    // Back-pressure: result held for 20 cycles while a competing operand is offered
    in_q      = 12'd100;
    in_r      = 5'd5;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_q = 12'd7;
    in_r = 5'd1;
    for (int k = 0; k < 5; k++) step();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("hold.vld%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold.x%0d", k), 32'(x_out), 32'd2305);
      chk($sformatf("hold.rdy%0d", k), 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("hold.pre_release", 32'(out_valid), 32'd1);
    step();
    chk("hold.released", 32'(out_valid), 32'd0);
    chk("hold.rdy_back", 32'(in_ready), 32'd1);
    chk("hold.x_kept", 32'(x_out), 32'd2305);

    // Asynchronous reset during CALC step 2
    in_q     = 12'd50;
    in_r     = 5'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.x", 32'(x_out), 32'd0);
    chk("areset.err", 32'(err_out), 32'd0);
    chk("areset.vld", 32'(out_valid), 32'd0);
    chk("areset.rdy", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("areset.idle_vld", 32'(out_valid), 32'd0);
    run("after_rst", 50, 3, 1153, 1'b0);

    // Round trip over a spread of dividends
    for (int x = 0; x < 65536; x += 4111) begin
      run($sformatf("rt%0d", x), x / 23, x % 23, x, 1'b0);
    end
    run("rt65535", 65535 / 23, 65535 % 23, 65535, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_recon_16_23
